// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter merging NUM_PORTS LC-3b style memory clients onto one memory port.
// One outstanding transaction; request fields are captured at grant and held until mem_resp.
module mem_port_arbiter #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16,
  localparam int unsigned MASK_WIDTH = DATA_WIDTH / 8,
  localparam int unsigned IDX_WIDTH  = $clog2(NUM_PORTS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PORTS-1:0]             cli_read,
  input  logic [NUM_PORTS-1:0]             cli_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  cli_address,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  cli_wdata,
  input  logic [NUM_PORTS*MASK_WIDTH-1:0]  cli_byte_enable,
  output logic [NUM_PORTS-1:0]             cli_resp,
  output logic [DATA_WIDTH-1:0]            cli_rdata,
  output logic                             mem_read,
  output logic                             mem_write,
  output logic [ADDR_WIDTH-1:0]            mem_address,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  output logic [MASK_WIDTH-1:0]            mem_byte_enable,
  input  logic                             mem_resp,
  input  logic [DATA_WIDTH-1:0]            mem_rdata,
  output logic [IDX_WIDTH-1:0]             grant_idx,
  output logic                             protocol_err
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e                r_state, w_state_d;
  logic                  r_mem_read, w_mem_read_d;
  logic                  r_mem_write, w_mem_write_d;
  logic [ADDR_WIDTH-1:0] r_mem_address, w_mem_address_d;
  logic [DATA_WIDTH-1:0] r_mem_wdata, w_mem_wdata_d;
  logic [MASK_WIDTH-1:0] r_mem_be, w_mem_be_d;
  logic [IDX_WIDTH-1:0]  r_grant_idx, w_grant_idx_d;
  logic                  r_protocol_err, w_protocol_err_d;

  logic [NUM_PORTS-1:0]  w_req;
  logic                  w_any_req;
  logic [IDX_WIDTH-1:0]  w_winner;
  logic [IDX_WIDTH-1:0]  w_sel;
  logic [31:0]           w_sum;
  logic                  w_sel_rd;
  logic                  w_sel_wr;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;
  logic [MASK_WIDTH-1:0] w_sel_be;

  // Scan starts one past the last grant so the most recent winner has lowest priority.
  always_comb begin
    w_req     = cli_read | cli_write;
    w_any_req = 1'b0;
    w_winner  = r_grant_idx;
    w_sum     = '0;
    w_sel     = '0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      w_sum = 32'(r_grant_idx) + k;
      w_sel = IDX_WIDTH'(w_sum % NUM_PORTS);
      if (!w_any_req && w_req[w_sel]) begin
        w_any_req = 1'b1;
        w_winner  = w_sel;
      end
    end
  end

  always_comb begin
    w_sel_rd    = 1'b0;
    w_sel_wr    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_be    = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (w_winner == IDX_WIDTH'(i)) begin
        w_sel_rd    = cli_read[i];
        w_sel_wr    = cli_write[i];
        w_sel_addr  = cli_address[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_wdata = cli_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        w_sel_be    = cli_byte_enable[i*MASK_WIDTH +: MASK_WIDTH];
      end
    end
  end

  always_comb begin
    w_state_d        = r_state;
    w_mem_read_d     = r_mem_read;
    w_mem_write_d    = r_mem_write;
    w_mem_address_d  = r_mem_address;
    w_mem_wdata_d    = r_mem_wdata;
    w_mem_be_d       = r_mem_be;
    w_grant_idx_d    = r_grant_idx;
    w_protocol_err_d = r_protocol_err;
    case (r_state)
      StIdle: begin
        if (w_any_req) begin
          w_state_d       = StBusy;
          w_mem_address_d = w_sel_addr;
          w_mem_wdata_d   = w_sel_wdata;
          w_mem_be_d      = w_sel_be;
          w_grant_idx_d   = w_winner;
          // A simultaneous read+write is resolved as a write and flagged.
          w_mem_write_d   = w_sel_wr;
          w_mem_read_d    = w_sel_rd & ~w_sel_wr;
          if (w_sel_rd && w_sel_wr) begin
            w_protocol_err_d = 1'b1;
          end
        end
      end
      StBusy: begin
        if (mem_resp) begin
          w_state_d     = StIdle;
          w_mem_read_d  = 1'b0;
          w_mem_write_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= StIdle;
      r_mem_read     <= 1'b0;
      r_mem_write    <= 1'b0;
      r_mem_address  <= '0;
      r_mem_wdata    <= '0;
      r_mem_be       <= '0;
      r_grant_idx    <= IDX_WIDTH'(NUM_PORTS - 1);
      r_protocol_err <= 1'b0;
    end else begin
      r_state        <= w_state_d;
      r_mem_read     <= w_mem_read_d;
      r_mem_write    <= w_mem_write_d;
      r_mem_address  <= w_mem_address_d;
      r_mem_wdata    <= w_mem_wdata_d;
      r_mem_be       <= w_mem_be_d;
      r_grant_idx    <= w_grant_idx_d;
      r_protocol_err <= w_protocol_err_d;
    end
  end

  always_comb begin
    cli_resp = '0;
    if (r_state == StBusy && mem_resp) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        cli_resp[i] = (r_grant_idx == IDX_WIDTH'(i));
      end
    end
  end

  assign cli_rdata       = mem_rdata;
  assign mem_read        = r_mem_read;
  assign mem_write       = r_mem_write;
  assign mem_address     = r_mem_address;
  assign mem_wdata       = r_mem_wdata;
  assign mem_byte_enable = r_mem_be;
  assign grant_idx       = r_grant_idx;
  assign protocol_err    = r_protocol_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: stimulus pushes expected grants; a negedge monitor pops and checks them.
// A second 4-port instance checks round-robin order with sparse requesters.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 2-port instance
  logic [1:0]  cli_read_a, cli_write_a, cli_resp_a;
  logic [31:0] cli_address_a, cli_wdata_a;
  logic [3:0]  cli_be_a;
  logic [15:0] cli_rdata_a;
  logic        mem_read_a, mem_write_a, mem_resp_a;
  logic [15:0] mem_address_a, mem_wdata_a, mem_rdata_a;
  logic [1:0]  mem_be_a;
  logic [0:0]  grant_idx_a;
  logic        perr_a;

  // 4-port instance
  logic [3:0]  cli_read_b, cli_write_b, cli_resp_b;
  logic [63:0] cli_address_b, cli_wdata_b;
  logic [7:0]  cli_be_b;
  logic [15:0] cli_rdata_b;
  logic        mem_read_b, mem_write_b, mem_resp_b;
  logic [15:0] mem_address_b, mem_wdata_b, mem_rdata_b;
  logic [1:0]  mem_be_b;
  logic [1:0]  grant_idx_b;
  logic        perr_b;

  mem_port_arbiter #(.NUM_PORTS(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .cli_read(cli_read_a), .cli_write(cli_write_a), .cli_address(cli_address_a),
    .cli_wdata(cli_wdata_a), .cli_byte_enable(cli_be_a), .cli_resp(cli_resp_a),
    .cli_rdata(cli_rdata_a), .mem_read(mem_read_a), .mem_write(mem_write_a),
    .mem_address(mem_address_a), .mem_wdata(mem_wdata_a), .mem_byte_enable(mem_be_a),
    .mem_resp(mem_resp_a), .mem_rdata(mem_rdata_a), .grant_idx(grant_idx_a),
    .protocol_err(perr_a)
  );

  mem_port_arbiter #(.NUM_PORTS(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .cli_read(cli_read_b), .cli_write(cli_write_b), .cli_address(cli_address_b),
    .cli_wdata(cli_wdata_b), .cli_byte_enable(cli_be_b), .cli_resp(cli_resp_b),
    .cli_rdata(cli_rdata_b), .mem_read(mem_read_b), .mem_write(mem_write_b),
    .mem_address(mem_address_b), .mem_wdata(mem_wdata_b), .mem_byte_enable(mem_be_b),
    .mem_resp(mem_resp_b), .mem_rdata(mem_rdata_b), .grant_idx(grant_idx_b),
    .protocol_err(perr_b)
  );

  typedef struct {
    int          port;
    bit          rd;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] rdata;
  } txn_t;

  txn_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  bit   mem_en  = 1'b1;
  int   resp_lat = 3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push(input int p, input bit rd, input bit wr, input logic [15:0] addr,
                      input logic [15:0] wdata, input logic [1:0] be, input logic [15:0] rdata);
    txn_t t;
    t.port = p; t.rd = rd; t.wr = wr; t.addr = addr; t.wdata = wdata; t.be = be;
    t.rdata = rdata;
    exp_q.push_back(t);
  endtask

  task automatic set_cli(input int p, input bit rd, input bit wr, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [1:0] be);
    cli_read_a[p]            = rd;
    cli_write_a[p]           = wr;
    cli_address_a[p*16 +: 16] = addr;
    cli_wdata_a[p*16 +: 16]   = wdata;
    cli_be_a[p*2 +: 2]        = be;
  endtask

  task automatic wait_resp_a();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cli_resp_a == 2'b00 && n < 60);
    if (cli_resp_a == 2'b00) chk("resp_timeout", 32'(cli_resp_a != 2'b00), 32'd1);
  endtask

  task automatic wait_grant_b();
    int n = 0;
    while ((mem_read_b || mem_write_b) && n < 60) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(mem_read_b || mem_write_b) && n < 60);
    if (!(mem_read_b || mem_write_b)) chk("grant_b_timeout", 32'(mem_read_b), 32'd1);
  endtask

  // Memory model for A: rdata = address ^ 16'hACDB, response resp_lat cycles after strobe.
  initial begin : responder_a
    mem_resp_a  = 1'b0;
    mem_rdata_a = '0;
    forever begin
      @(posedge clk);
      #1;
      if ((mem_read_a || mem_write_a) && mem_en && rst_n) begin
        repeat (resp_lat) @(posedge clk);
        #1;
        mem_resp_a  = 1'b1;
        mem_rdata_a = mem_address_a ^ 16'hACDB;
        @(posedge clk);
        #1;
        mem_resp_a  = 1'b0;
      end
    end
  end

  initial begin : responder_b
    mem_resp_b  = 1'b0;
    mem_rdata_b = '0;
    forever begin
      @(posedge clk);
      #1;
      if ((mem_read_b || mem_write_b) && rst_n) begin
        @(posedge clk);
        #1;
        mem_resp_b = 1'b1;
        @(posedge clk);
        #1;
        mem_resp_b = 1'b0;
      end
    end
  end

  initial begin : monitor_a
    txn_t cur;
    bit   cur_valid   = 1'b0;
    bit   prev_strobe = 1'b0;
    bit   prev_resp   = 1'b0;
    bit   strobe;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cur_valid   = 1'b0;
        prev_strobe = 1'b0;
        prev_resp   = 1'b0;
      end else begin
        strobe = mem_read_a | mem_write_a;
        if (prev_resp) chk("idle_gap", {29'd0, strobe, cli_resp_a}, 32'd0);
        if (strobe && !prev_strobe) begin
          if (exp_q.size() == 0) begin
            chk("grant_expected", 32'(exp_q.size()), 32'd1);
          end else begin
            cur = exp_q.pop_front();
            cur_valid = 1'b1;
            chk("grant_idx", 32'(grant_idx_a), 32'(cur.port));
            chk("mem_read", 32'(mem_read_a), 32'(cur.rd));
            chk("mem_write", 32'(mem_write_a), 32'(cur.wr));
            chk("mem_address", 32'(mem_address_a), 32'(cur.addr));
            chk("mem_byte_enable", 32'(mem_be_a), 32'(cur.be));
            if (cur.wr) chk("mem_wdata", 32'(mem_wdata_a), 32'(cur.wdata));
          end
        end
        if (cli_resp_a != 2'b00) begin
          if (!cur_valid) begin
            chk("resp_without_grant", 32'(cli_resp_a), 32'd0);
          end else begin
            chk("cli_resp", 32'(cli_resp_a), 32'd1 << cur.port);
            chk("cli_rdata", 32'(cli_rdata_a), 32'(cur.rdata));
            chk("held_address", 32'(mem_address_a), 32'(cur.addr));
            chk("held_byte_enable", 32'(mem_be_a), 32'(cur.be));
            if (cur.wr) chk("held_wdata", 32'(mem_wdata_a), 32'(cur.wdata));
            cur_valid = 1'b0;
          end
        end
        prev_strobe = strobe;
        prev_resp   = (cli_resp_a != 2'b00);
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin : stimulus
    rst_n = 1'b0;
    cli_read_a = '0; cli_write_a = '0; cli_address_a = '0; cli_wdata_a = '0; cli_be_a = '0;
    cli_read_b = '0; cli_write_b = '0; cli_address_b = '0; cli_wdata_b = '0; cli_be_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_mem_read", 32'(mem_read_a), 32'd0);
    chk("rst_mem_write", 32'(mem_write_a), 32'd0);
    chk("rst_mem_address", 32'(mem_address_a), 32'd0);
    chk("rst_grant_idx", 32'(grant_idx_a), 32'd1);
    chk("rst_grant_idx_b", 32'(grant_idx_b), 32'd3);
    chk("rst_protocol_err", 32'(perr_a), 32'd0);
    chk("rst_cli_resp", 32'(cli_resp_a), 32'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Client 0 read, strobe one cycle after the request, data returned 0xBEEF.
    resp_lat = 3;
    set_cli(0, 1'b1, 1'b0, 16'h1234, 16'h0000, 2'b11);
    push(0, 1'b1, 1'b0, 16'h1234, 16'h0000, 2'b11, 16'hBEEF);
    @(posedge clk);
    #1;
    chk("t1_strobe_latency", 32'(mem_read_a), 32'd1);
    wait_resp_a();
    set_cli(0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    repeat (2) @(negedge clk);

    // Both clients request continuously: grants 1,0,1,0 after the last grant to 0.
    resp_lat = 1;
    set_cli(0, 1'b1, 1'b0, 16'h0100, 16'h0000, 2'b11);
    set_cli(1, 1'b1, 1'b0, 16'h0200, 16'h0000, 2'b11);
    push(1, 1'b1, 1'b0, 16'h0200, 16'h0000, 2'b11, 16'hAEDB);
    push(0, 1'b1, 1'b0, 16'h0100, 16'h0000, 2'b11, 16'hADDB);
    push(1, 1'b1, 1'b0, 16'h0200, 16'h0000, 2'b11, 16'hAEDB);
    push(0, 1'b1, 1'b0, 16'h0100, 16'h0000, 2'b11, 16'hADDB);
    repeat (4) wait_resp_a();
    set_cli(0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    set_cli(1, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    repeat (2) @(negedge clk);

    // Client 1 write; its fields change while busy and must not leak through.
    resp_lat = 3;
    set_cli(1, 1'b0, 1'b1, 16'h0040, 16'hA5A5, 2'b10);
    push(1, 1'b0, 1'b1, 16'h0040, 16'hA5A5, 2'b10, 16'hAC9B);
    repeat (2) @(negedge clk);
    set_cli(1, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 2'b01);
    wait_resp_a();
    set_cli(1, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    repeat (2) @(negedge clk);

    // Client 0 read+write together: treated as write, sticky protocol_err.
    resp_lat = 1;
    set_cli(0, 1'b1, 1'b1, 16'h0ABC, 16'h1357, 2'b01);
    push(0, 1'b0, 1'b1, 16'h0ABC, 16'h1357, 2'b01, 16'hA667);
    wait_resp_a();
    set_cli(0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    @(negedge clk);
    chk("t4_protocol_err", 32'(perr_a), 32'd1);
    set_cli(1, 1'b1, 1'b0, 16'h0002, 16'h0000, 2'b11);
    push(1, 1'b1, 1'b0, 16'h0002, 16'h0000, 2'b11, 16'hACD9);
    wait_resp_a();
    set_cli(1, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    @(negedge clk);
    chk("t4_protocol_err_sticky", 32'(perr_a), 32'd1);

    // Reset during a busy transaction that memory never answers.
    mem_en = 1'b0;
    set_cli(1, 1'b1, 1'b0, 16'h0300, 16'h0000, 2'b11);
    push(1, 1'b1, 1'b0, 16'h0300, 16'h0000, 2'b11, 16'h0000);
    repeat (3) @(negedge clk);
    chk("t5_busy_before_reset", 32'(mem_read_a), 32'd1);
    #2 rst_n = 1'b0;
    set_cli(1, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    #1;
    chk("t5_rst_mem_read", 32'(mem_read_a), 32'd0);
    chk("t5_rst_mem_write", 32'(mem_write_a), 32'd0);
    chk("t5_rst_protocol_err", 32'(perr_a), 32'd0);
    chk("t5_rst_mem_address", 32'(mem_address_a), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    mem_en = 1'b1;
    @(negedge clk);
    set_cli(0, 1'b1, 1'b0, 16'h0500, 16'h0000, 2'b11);
    set_cli(1, 1'b1, 1'b0, 16'h0600, 16'h0000, 2'b11);
    push(0, 1'b1, 1'b0, 16'h0500, 16'h0000, 2'b11, 16'hA9DB);
    push(1, 1'b1, 1'b0, 16'h0600, 16'h0000, 2'b11, 16'hAADB);
    repeat (2) wait_resp_a();
    set_cli(0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    set_cli(1, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    repeat (3) @(negedge clk);

    // 4-port: only clients 1 and 3 request -> 1, then 3,1,3.
    cli_read_b = 4'b0010;
    wait_grant_b();
    chk("t6_grant_first", 32'(grant_idx_b), 32'd1);
    cli_read_b = 4'b1010;
    wait_grant_b();
    chk("t6_grant_second", 32'(grant_idx_b), 32'd3);
    wait_grant_b();
    chk("t6_grant_third", 32'(grant_idx_b), 32'd1);
    wait_grant_b();
    chk("t6_grant_fourth", 32'(grant_idx_b), 32'd3);
    cli_read_b = 4'b0000;
    repeat (8) @(negedge clk);
    chk("t6_idle_after", 32'(mem_read_b), 32'd0);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
